// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath types and constants for the HI/LO sequencer
package mips_pkg;

    localparam int   WORD_W  = 32;
    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        DONE,
        DIV0
    } md_state_t;

endpackage

// File: rtl/mult_div_seq_if.sv
// rtl/mult_div_seq_if.sv - request/result bundle between main control and the HI/LO sequencer
interface mult_div_seq_if
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Div0;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, done, Div0, HI, LO);
    modport slave  (input start, op, A, B, output busy, done, Div0, HI, LO);
endinterface

// File: rtl/hilo_addsub.sv
// rtl/hilo_addsub.sv - WIDTH+1-bit adder/subtractor shared by Booth steps and division trial subtracts
module hilo_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    input  logic           i_sub,
    output logic [WIDTH:0] o_sum,
    output logic           o_sign
);
    logic [WIDTH:0] w_b;

    assign w_b    = i_sub ? ~i_b : i_b;
    assign o_sum  = i_a + w_b + {{WIDTH{1'b0}}, i_sub};
    assign o_sign = o_sum[WIDTH];
endmodule

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - multicycle signed Booth multiply / restoring divide owning HI/LO
module mult_div_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           RESET_in,
    mult_div_seq_if.slave  bus
);
    md_state_t        r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op, r_q1, r_sign_q, r_sign_r;
    logic [WIDTH-1:0] r_a, r_p_hi, r_p_lo, r_hi, r_lo;

    logic             w_accept, w_div_zero, w_last;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [1:0]       w_booth;
    logic [WIDTH:0]   w_add_a, w_add_b, w_sum;
    logic             w_add_sub, w_sign;

    assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
    assign w_div_zero = w_accept && (bus.op == MD_DIV) && (bus.B == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_abs_a    = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign w_abs_b    = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // Multiply: {r_p_hi, r_p_lo, r_q1} is the Booth product register, r_a the multiplicand.
    // Divide: r_p_hi is the partial remainder, r_p_lo the dividend/quotient, r_a = |divisor|.
    assign w_booth   = {r_p_lo[0], r_q1};
    assign w_add_a   = (r_op == MD_MULT) ? {r_p_hi[WIDTH-1], r_p_hi} : {r_p_hi, r_p_lo[WIDTH-1]};
    assign w_add_b   = (r_op == MD_DIV) ? {1'b0, r_a} :
                       (w_booth[1] ^ w_booth[0]) ? {r_a[WIDTH-1], r_a} : '0;
    assign w_add_sub = (r_op == MD_DIV) || (w_booth == 2'b10);

    hilo_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (w_add_sub),
        .o_sum  (w_sum),
        .o_sign (w_sign)
    );

    always_ff @(posedge clock) begin
        if (RESET_in) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_next = w_div_zero ? DIV0 : RUN;
                else          w_next = IDLE;
            end
            RUN:     if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DIV0:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (RESET_in) begin
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_q1     <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_a      <= '0;
            r_p_hi   <= '0;
            r_p_lo   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept && !w_div_zero) begin
                        r_op     <= bus.op;
                        r_cnt    <= '0;
                        r_q1     <= 1'b0;
                        r_p_hi   <= '0;
                        r_sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        r_sign_r <= bus.A[WIDTH-1];
                        r_a      <= (bus.op == MD_MULT) ? bus.A : w_abs_b;
                        r_p_lo   <= (bus.op == MD_MULT) ? bus.B : w_abs_a;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == MD_MULT) begin
                        r_p_hi <= w_sum[WIDTH:1];
                        r_p_lo <= {w_sum[0], r_p_lo[WIDTH-1:1]};
                        r_q1   <= r_p_lo[0];
                    end else begin
                        // Partial remainder stays below |B|, so the sign bit alone decides restore.
                        r_p_hi <= w_sign ? w_add_a[WIDTH-1:0] : w_sum[WIDTH-1:0];
                        r_p_lo <= {r_p_lo[WIDTH-2:0], ~w_sign};
                    end
                end
                FIX: begin
                    if (r_op == MD_MULT) begin
                        r_hi <= r_p_hi;
                        r_lo <= r_p_lo;
                    end else begin
                        r_hi <= r_sign_r ? -r_p_hi : r_p_hi;
                        r_lo <= r_sign_q ? -r_p_lo : r_p_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == RUN) || (r_state == FIX) || (r_state == DIV0);
    assign bus.done = (r_state == DONE);
    assign bus.Div0 = (r_state == DIV0);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - randomized self-checking bench for mult_div_seq against an arithmetic model
module tb_mult_div_seq;
    logic clock;
    logic RESET_in;
    int   total = 0;
    int   bad   = 0;

    mult_div_seq_if #(.WIDTH(32)) bus ();

    mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock    (clock),
        .RESET_in (RESET_in),
        .bus      (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {HI, LO} from plain signed arithmetic; longint keeps MIN / -1 well defined.
    function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q, r;
        if (o == 1'b0) return 64'(sa * sb);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request at edge 0 and observes cycles 1..60 (stops at done).
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit noise,
                          output int done_at, output int busy_n, output int div0_at, output int div0_n);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        done_at = -1; busy_n = 0; div0_at = -1; div0_n = 0;
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            if (bus.busy) busy_n++;
            if (bus.Div0) begin
                div0_n++;
                if (div0_at < 0) div0_at = k;
            end
            if (bus.done) done_at = k;
            if (done_at < 0) begin
                bus.start = noise && (k == 4);
                bus.op    = 1'($urandom);
                tick();
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        RESET_in = 1'b1;
        bus.start = 1'b0; bus.op = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) tick();
        RESET_in = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.Div0 !== 1'b0) begin bad++; $display("FAIL reset_div0 got=%b want=0", bus.Div0); end
        total++; if (bus.HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.HI); end
        total++; if (bus.LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.LO); end
    endtask

    task automatic test_mult_directed();
        logic [31:0] av [2] = '{32'd7, 32'h7FFFFFFF};
        logic [31:0] bv [2] = '{32'hFFFFFFFD, 32'h7FFFFFFF};
        int d, bn, z, zn;
        logic [63:0] exp;
        for (int i = 0; i < 2; i++) begin
            exp = model(1'b0, av[i], bv[i]);
            run_op(1'b0, av[i], bv[i], 1'b0, d, bn, z, zn);
            total++; if (d !== 34) begin bad++; $display("FAIL mult_done_cycle got=%0d want=34", d); end
            total++; if (bn !== 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d want=33", bn); end
            total++; if (bus.HI !== exp[63:32]) begin bad++; $display("FAIL mult_hi got=%h want=%h", bus.HI, exp[63:32]); end
            total++; if (bus.LO !== exp[31:0]) begin bad++; $display("FAIL mult_lo got=%h want=%h", bus.LO, exp[31:0]); end
            tick();
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b want=0", bus.done); end
            total++; if (bus.HI !== exp[63:32]) begin bad++; $display("FAIL mult_hi_hold got=%h want=%h", bus.HI, exp[63:32]); end
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(3, 0) == 0) return corner[$urandom_range(4, 0)];
        return $urandom;
    endfunction

    task automatic test_mult_random();
        logic [31:0] a, b;
        logic [63:0] exp;
        int d, bn, z, zn;
        for (int i = 0; i < 16; i++) begin
            a = pick(); b = pick();
            exp = model(1'b0, a, b);
            run_op(1'b0, a, b, 1'b0, d, bn, z, zn);
            total++; if (d !== 34) begin bad++; $display("FAIL mrand_done_cycle got=%0d want=34", d); end
            total++; if ({bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL mrand_product a=%h b=%h got=%h want=%h", a, b, {bus.HI, bus.LO}, exp); end
        end
    endtask

    task automatic test_div();
        logic [31:0] av [4] = '{32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'd7};
        logic [31:0] bv [4] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE};
        logic [31:0] a, b;
        logic [63:0] exp;
        int d, bn, z, zn;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin a = av[i]; b = bv[i]; end
            else begin
                a = pick(); b = pick();
                if (b == 32'h0) b = 32'd3;
            end
            exp = model(1'b1, a, b);
            run_op(1'b1, a, b, 1'b0, d, bn, z, zn);
            total++; if (d !== 34) begin bad++; $display("FAIL div_done_cycle got=%0d want=34", d); end
            total++; if ({bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL div_result a=%h b=%h got=%h want=%h", a, b, {bus.HI, bus.LO}, exp); end
            total++; if (zn !== 0) begin bad++; $display("FAIL div_flag got=%0d want=0", zn); end
        end
    endtask

    task automatic test_div0();
        int d, bn, z, zn;
        run_op(1'b1, 32'd47, 32'd7, 1'b0, d, bn, z, zn);
        total++; if ({bus.HI, bus.LO} !== {32'd5, 32'd6}) begin bad++; $display("FAIL div0_setup got=%h want=%h", {bus.HI, bus.LO}, {32'd5, 32'd6}); end
        run_op(1'b1, 32'd100, 32'd0, 1'b0, d, bn, z, zn);
        total++; if (z !== 1) begin bad++; $display("FAIL div0_cycle got=%0d want=1", z); end
        total++; if (zn !== 1) begin bad++; $display("FAIL div0_width got=%0d want=1", zn); end
        total++; if (bn !== 1) begin bad++; $display("FAIL div0_busy_cycles got=%0d want=1", bn); end
        total++; if (d !== -1) begin bad++; $display("FAIL div0_done got=%0d want=-1", d); end
        total++; if (bus.HI !== 32'd5) begin bad++; $display("FAIL div0_hi got=%h want=5", bus.HI); end
        total++; if (bus.LO !== 32'd6) begin bad++; $display("FAIL div0_lo got=%h want=6", bus.LO); end
    endtask

    task automatic test_reset_abort();
        int dn;
        for (int pass = 0; pass < 2; pass++) begin
            bus.start = 1'b1; bus.op = 1'b0; bus.A = $urandom | 32'h1; bus.B = $urandom | 32'h1;
            tick();
            bus.start = 1'b0;
            repeat (10) tick();
            RESET_in  = 1'b1;
            bus.start = (pass == 1);
            tick();
            RESET_in  = 1'b0;
            bus.start = 1'b0;
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy pass=%0d got=%b want=0", pass, bus.busy); end
            total++; if ({bus.HI, bus.LO} !== 64'h0) begin bad++; $display("FAIL abort_hilo pass=%0d got=%h want=0", pass, {bus.HI, bus.LO}); end
            dn = 0;
            for (int k = 0; k < 40; k++) begin
                if (bus.done || bus.busy) dn++;
                tick();
            end
            total++; if (dn !== 0) begin bad++; $display("FAIL abort_activity pass=%0d got=%0d want=0", pass, dn); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        o;
        logic [63:0] exp;
        int d, bn, z, zn;
        run_op(1'b0, 32'd3, 32'd4, 1'b0, d, bn, z, zn);
        total++; if (bus.LO !== 32'd12) begin bad++; $display("FAIL b2b_first_lo got=%h want=c", bus.LO); end
        run_op(1'b1, 32'd9, 32'd2, 1'b1, d, bn, z, zn);
        total++; if (d !== 34) begin bad++; $display("FAIL b2b_second_cycle got=%0d want=34", d); end
        total++; if ({bus.HI, bus.LO} !== {32'd1, 32'd4}) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", {bus.HI, bus.LO}, {32'd1, 32'd4}); end
        for (int i = 0; i < 6; i++) begin
            o = 1'($urandom); a = pick(); b = pick();
            if (o && b == 32'h0) b = 32'd5;
            exp = model(o, a, b);
            run_op(o, a, b, 1'b1, d, bn, z, zn);
            total++; if (d !== 34) begin bad++; $display("FAIL b2b_chain_cycle got=%0d want=34", d); end
            total++; if ({bus.HI, bus.LO} !== exp) begin bad++; $display("FAIL b2b_chain op=%b a=%h b=%h got=%h want=%h", o, a, b, {bus.HI, bus.LO}, exp); end
        end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b want=0", bus.done); end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_mult_random();
        test_div();
        test_div0();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
